axi_dual_master_arbiter: RTL and testbench

Shares one AXI4 slave port between two AXI4 masters of equal data width: master 0 (core data port) and master 1 (wide fetch/DMA port after width conversion). It sits in the memory subsystem ahead of the address decoder, in front of the scratchpad, flash, UART and GPIO targets. Read and write directions are arbitrated independently with round-robin fairness, one outstanding transaction per direction. The downstream ID is extended by one bit carrying the grant index.

---
 rtl/axi_dual_master_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_dual_master_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dual_master_arbiter.sv
// rtl/axi_dual_master_arbiter.sv - two AXI4 masters onto one slave port, round-robin per direction
module axi_dual_master_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  // master 0
  input  logic                    s0_aw_valid,
  output logic                    s0_aw_ready,
  input  logic [ID_WIDTH-1:0]     s0_aw_bits_id,
  input  logic [ADDR_WIDTH-1:0]   s0_aw_bits_addr,
  input  logic [7:0]              s0_aw_bits_len,
  input  logic [2:0]              s0_aw_bits_size,
  input  logic [1:0]              s0_aw_bits_burst,
  input  logic                    s0_w_valid,
  output logic                    s0_w_ready,
  input  logic [DATA_WIDTH-1:0]   s0_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] s0_w_bits_strb,
  input  logic                    s0_w_bits_last,
  output logic                    s0_b_valid,
  input  logic                    s0_b_ready,
  output logic [ID_WIDTH-1:0]     s0_b_bits_id,
  output logic [1:0]              s0_b_bits_resp,
  input  logic                    s0_ar_valid,
  output logic                    s0_ar_ready,
  input  logic [ID_WIDTH-1:0]     s0_ar_bits_id,
  input  logic [ADDR_WIDTH-1:0]   s0_ar_bits_addr,
  input  logic [7:0]              s0_ar_bits_len,
  input  logic [2:0]              s0_ar_bits_size,
  input  logic [1:0]              s0_ar_bits_burst,
  output logic                    s0_r_valid,
  input  logic                    s0_r_ready,
  output logic [ID_WIDTH-1:0]     s0_r_bits_id,
  output logic [DATA_WIDTH-1:0]   s0_r_bits_data,
  output logic [1:0]              s0_r_bits_resp,
  output logic                    s0_r_bits_last,
  // master 1
  input  logic                    s1_aw_valid,
  output logic                    s1_aw_ready,
  input  logic [ID_WIDTH-1:0]     s1_aw_bits_id,
  input  logic [ADDR_WIDTH-1:0]   s1_aw_bits_addr,
  input  logic [7:0]              s1_aw_bits_len,
  input  logic [2:0]              s1_aw_bits_size,
  input  logic [1:0]              s1_aw_bits_burst,
  input  logic                    s1_w_valid,
  output logic                    s1_w_ready,
  input  logic [DATA_WIDTH-1:0]   s1_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] s1_w_bits_strb,
  input  logic                    s1_w_bits_last,
  output logic                    s1_b_valid,
  input  logic                    s1_b_ready,
  output logic [ID_WIDTH-1:0]     s1_b_bits_id,
  output logic [1:0]              s1_b_bits_resp,
  input  logic                    s1_ar_valid,
  output logic                    s1_ar_ready,
  input  logic [ID_WIDTH-1:0]     s1_ar_bits_id,
  input  logic [ADDR_WIDTH-1:0]   s1_ar_bits_addr,
  input  logic [7:0]              s1_ar_bits_len,
  input  logic [2:0]              s1_ar_bits_size,
  input  logic [1:0]              s1_ar_bits_burst,
  output logic                    s1_r_valid,
  input  logic                    s1_r_ready,
  output logic [ID_WIDTH-1:0]     s1_r_bits_id,
  output logic [DATA_WIDTH-1:0]   s1_r_bits_data,
  output logic [1:0]              s1_r_bits_resp,
  output logic                    s1_r_bits_last,
  // downstream slave port
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  output logic [ID_WIDTH:0]       m_aw_bits_id,
  output logic [ADDR_WIDTH-1:0]   m_aw_bits_addr,
  output logic [7:0]              m_aw_bits_len,
  output logic [2:0]              m_aw_bits_size,
  output logic [1:0]              m_aw_bits_burst,
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  output logic [DATA_WIDTH-1:0]   m_w_bits_data,
  output logic [DATA_WIDTH/8-1:0] m_w_bits_strb,
  output logic                    m_w_bits_last,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  input  logic [ID_WIDTH:0]       m_b_bits_id,
  input  logic [1:0]              m_b_bits_resp,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  output logic [ID_WIDTH:0]       m_ar_bits_id,
  output logic [ADDR_WIDTH-1:0]   m_ar_bits_addr,
  output logic [7:0]              m_ar_bits_len,
  output logic [2:0]              m_ar_bits_size,
  output logic [1:0]              m_ar_bits_burst,
  input  logic                    m_r_valid,
  output logic                    m_r_ready,
  input  logic [ID_WIDTH:0]       m_r_bits_id,
  input  logic [DATA_WIDTH-1:0]   m_r_bits_data,
  input  logic [1:0]              m_r_bits_resp,
  input  logic                    m_r_bits_last
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_RESP} w_state_t;

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;
  logic r_grant, r_grant_nxt, r_last_grant, r_last_nxt;
  logic w_grant, w_grant_nxt, w_last_grant, w_last_nxt;
  logic aw_done, aw_done_nxt, w_done, w_done_nxt;

  // Responses are routed by the grant register; the returned ID MSB is ignored.
  logic r_id_msb_unused, b_id_msb_unused;
  assign r_id_msb_unused = m_r_bits_id[ID_WIDTH];
  assign b_id_msb_unused = m_b_bits_id[ID_WIDTH];

  assign m_ar_bits_id    = r_grant ? {1'b1, s1_ar_bits_id} : {1'b0, s0_ar_bits_id};
  assign m_ar_bits_addr  = r_grant ? s1_ar_bits_addr  : s0_ar_bits_addr;
  assign m_ar_bits_len   = r_grant ? s1_ar_bits_len   : s0_ar_bits_len;
  assign m_ar_bits_size  = r_grant ? s1_ar_bits_size  : s0_ar_bits_size;
  assign m_ar_bits_burst = r_grant ? s1_ar_bits_burst : s0_ar_bits_burst;
  assign m_aw_bits_id    = w_grant ? {1'b1, s1_aw_bits_id} : {1'b0, s0_aw_bits_id};
  assign m_aw_bits_addr  = w_grant ? s1_aw_bits_addr  : s0_aw_bits_addr;
  assign m_aw_bits_len   = w_grant ? s1_aw_bits_len   : s0_aw_bits_len;
  assign m_aw_bits_size  = w_grant ? s1_aw_bits_size  : s0_aw_bits_size;
  assign m_aw_bits_burst = w_grant ? s1_aw_bits_burst : s0_aw_bits_burst;
  assign m_w_bits_data   = w_grant ? s1_w_bits_data : s0_w_bits_data;
  assign m_w_bits_strb   = w_grant ? s1_w_bits_strb : s0_w_bits_strb;
  assign m_w_bits_last   = w_grant ? s1_w_bits_last : s0_w_bits_last;

  assign s0_r_bits_id   = m_r_bits_id[ID_WIDTH-1:0];
  assign s1_r_bits_id   = m_r_bits_id[ID_WIDTH-1:0];
  assign s0_r_bits_data = m_r_bits_data;
  assign s1_r_bits_data = m_r_bits_data;
  assign s0_r_bits_resp = m_r_bits_resp;
  assign s1_r_bits_resp = m_r_bits_resp;
  assign s0_r_bits_last = m_r_bits_last;
  assign s1_r_bits_last = m_r_bits_last;
  assign s0_b_bits_id   = m_b_bits_id[ID_WIDTH-1:0];
  assign s1_b_bits_id   = m_b_bits_id[ID_WIDTH-1:0];
  assign s0_b_bits_resp = m_b_bits_resp;
  assign s1_b_bits_resp = m_b_bits_resp;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= R_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      w_state      <= W_IDLE;
      w_grant      <= 1'b0;
      w_last_grant <= 1'b1;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
    end else begin
      r_state      <= r_state_nxt;
      r_grant      <= r_grant_nxt;
      r_last_grant <= r_last_nxt;
      w_state      <= w_state_nxt;
      w_grant      <= w_grant_nxt;
      w_last_grant <= w_last_nxt;
      aw_done      <= aw_done_nxt;
      w_done       <= w_done_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    r_grant_nxt = r_grant;
    r_last_nxt  = r_last_grant;
    m_ar_valid  = 1'b0;
    s0_ar_ready = 1'b0;
    s1_ar_ready = 1'b0;
    s0_r_valid  = 1'b0;
    s1_r_valid  = 1'b0;
    m_r_ready   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s0_ar_valid || s1_ar_valid) begin
          r_grant_nxt = (s0_ar_valid && s1_ar_valid) ? ~r_last_grant : s1_ar_valid;
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        m_ar_valid  = r_grant ? s1_ar_valid : s0_ar_valid;
        s0_ar_ready = ~r_grant & m_ar_ready;
        s1_ar_ready =  r_grant & m_ar_ready;
        if (m_ar_valid && m_ar_ready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s0_r_valid = ~r_grant & m_r_valid;
        s1_r_valid =  r_grant & m_r_valid;
        m_r_ready  = r_grant ? s1_r_ready : s0_r_ready;
        if (m_r_valid && m_r_ready && m_r_bits_last) begin
          r_state_nxt = R_IDLE;
          r_last_nxt  = r_grant;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_nxt = w_state;
    w_grant_nxt = w_grant;
    w_last_nxt  = w_last_grant;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    m_aw_valid  = 1'b0;
    m_w_valid   = 1'b0;
    s0_aw_ready = 1'b0;
    s1_aw_ready = 1'b0;
    s0_w_ready  = 1'b0;
    s1_w_ready  = 1'b0;
    s0_b_valid  = 1'b0;
    s1_b_valid  = 1'b0;
    m_b_ready   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s0_aw_valid || s1_aw_valid) begin
          w_grant_nxt = (s0_aw_valid && s1_aw_valid) ? ~w_last_grant : s1_aw_valid;
          w_state_nxt = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        // AW and W complete independently; each channel closes once its handshake is done.
        m_aw_valid  = ~aw_done & (w_grant ? s1_aw_valid : s0_aw_valid);
        m_w_valid   = ~w_done & (w_grant ? s1_w_valid : s0_w_valid);
        s0_aw_ready = ~w_grant & ~aw_done & m_aw_ready;
        s1_aw_ready =  w_grant & ~aw_done & m_aw_ready;
        s0_w_ready  = ~w_grant & ~w_done & m_w_ready;
        s1_w_ready  =  w_grant & ~w_done & m_w_ready;
        aw_done_nxt = aw_done | (m_aw_valid & m_aw_ready);
        w_done_nxt  = w_done | (m_w_valid & m_w_ready & m_w_bits_last);
        if (aw_done_nxt && w_done_nxt) begin
          w_state_nxt = W_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      W_RESP: begin
        s0_b_valid = ~w_grant & m_b_valid;
        s1_b_valid =  w_grant & m_b_valid;
        m_b_ready  = w_grant ? s1_b_ready : s0_b_ready;
        if (m_b_valid && m_b_ready) begin
          w_state_nxt = W_IDLE;
          w_last_nxt  = w_grant;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_dual_master_arbiter.sv
// tb/tb_axi_dual_master_arbiter.sv - directed table-driven bench for axi_dual_master_arbiter
module tb_axi_dual_master_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic s0_aw_valid, s0_aw_ready, s1_aw_valid, s1_aw_ready;
  logic [IW-1:0] s0_aw_bits_id, s1_aw_bits_id;
  logic [AW-1:0] s0_aw_bits_addr, s1_aw_bits_addr;
  logic [7:0] s0_aw_bits_len, s1_aw_bits_len;
  logic [2:0] s0_aw_bits_size, s1_aw_bits_size;
  logic [1:0] s0_aw_bits_burst, s1_aw_bits_burst;
  logic s0_w_valid, s0_w_ready, s1_w_valid, s1_w_ready, s0_w_bits_last, s1_w_bits_last;
  logic [DW-1:0] s0_w_bits_data, s1_w_bits_data;
  logic [DW/8-1:0] s0_w_bits_strb, s1_w_bits_strb;
  logic s0_b_valid, s0_b_ready, s1_b_valid, s1_b_ready;
  logic [IW-1:0] s0_b_bits_id, s1_b_bits_id;
  logic [1:0] s0_b_bits_resp, s1_b_bits_resp;
  logic s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
  logic [IW-1:0] s0_ar_bits_id, s1_ar_bits_id;
  logic [AW-1:0] s0_ar_bits_addr, s1_ar_bits_addr;
  logic [7:0] s0_ar_bits_len, s1_ar_bits_len;
  logic [2:0] s0_ar_bits_size, s1_ar_bits_size;
  logic [1:0] s0_ar_bits_burst, s1_ar_bits_burst;
  logic s0_r_valid, s0_r_ready, s1_r_valid, s1_r_ready, s0_r_bits_last, s1_r_bits_last;
  logic [IW-1:0] s0_r_bits_id, s1_r_bits_id;
  logic [DW-1:0] s0_r_bits_data, s1_r_bits_data;
  logic [1:0] s0_r_bits_resp, s1_r_bits_resp;
  logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_bits_last;
  logic [IW:0] m_aw_bits_id, m_b_bits_id, m_ar_bits_id, m_r_bits_id;
  logic [AW-1:0] m_aw_bits_addr, m_ar_bits_addr;
  logic [7:0] m_aw_bits_len, m_ar_bits_len;
  logic [2:0] m_aw_bits_size, m_ar_bits_size;
  logic [1:0] m_aw_bits_burst, m_ar_bits_burst, m_b_bits_resp, m_r_bits_resp;
  logic [DW-1:0] m_w_bits_data, m_r_bits_data;
  logic [DW/8-1:0] m_w_bits_strb;
  logic m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_bits_last;

  axi_dual_master_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clock(clock), .reset(reset),
    .s0_aw_valid(s0_aw_valid), .s0_aw_ready(s0_aw_ready), .s0_aw_bits_id(s0_aw_bits_id),
    .s0_aw_bits_addr(s0_aw_bits_addr), .s0_aw_bits_len(s0_aw_bits_len), .s0_aw_bits_size(s0_aw_bits_size),
    .s0_aw_bits_burst(s0_aw_bits_burst), .s0_w_valid(s0_w_valid), .s0_w_ready(s0_w_ready),
    .s0_w_bits_data(s0_w_bits_data), .s0_w_bits_strb(s0_w_bits_strb), .s0_w_bits_last(s0_w_bits_last),
    .s0_b_valid(s0_b_valid), .s0_b_ready(s0_b_ready), .s0_b_bits_id(s0_b_bits_id), .s0_b_bits_resp(s0_b_bits_resp),
    .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_bits_id(s0_ar_bits_id),
    .s0_ar_bits_addr(s0_ar_bits_addr), .s0_ar_bits_len(s0_ar_bits_len), .s0_ar_bits_size(s0_ar_bits_size),
    .s0_ar_bits_burst(s0_ar_bits_burst), .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
    .s0_r_bits_id(s0_r_bits_id), .s0_r_bits_data(s0_r_bits_data), .s0_r_bits_resp(s0_r_bits_resp),
    .s0_r_bits_last(s0_r_bits_last),
    .s1_aw_valid(s1_aw_valid), .s1_aw_ready(s1_aw_ready), .s1_aw_bits_id(s1_aw_bits_id),
    .s1_aw_bits_addr(s1_aw_bits_addr), .s1_aw_bits_len(s1_aw_bits_len), .s1_aw_bits_size(s1_aw_bits_size),
    .s1_aw_bits_burst(s1_aw_bits_burst), .s1_w_valid(s1_w_valid), .s1_w_ready(s1_w_ready),
    .s1_w_bits_data(s1_w_bits_data), .s1_w_bits_strb(s1_w_bits_strb), .s1_w_bits_last(s1_w_bits_last),
    .s1_b_valid(s1_b_valid), .s1_b_ready(s1_b_ready), .s1_b_bits_id(s1_b_bits_id), .s1_b_bits_resp(s1_b_bits_resp),
    .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_bits_id(s1_ar_bits_id),
    .s1_ar_bits_addr(s1_ar_bits_addr), .s1_ar_bits_len(s1_ar_bits_len), .s1_ar_bits_size(s1_ar_bits_size),
    .s1_ar_bits_burst(s1_ar_bits_burst), .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
    .s1_r_bits_id(s1_r_bits_id), .s1_r_bits_data(s1_r_bits_data), .s1_r_bits_resp(s1_r_bits_resp),
    .s1_r_bits_last(s1_r_bits_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_bits_id(m_aw_bits_id),
    .m_aw_bits_addr(m_aw_bits_addr), .m_aw_bits_len(m_aw_bits_len), .m_aw_bits_size(m_aw_bits_size),
    .m_aw_bits_burst(m_aw_bits_burst), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_w_bits_data(m_w_bits_data), .m_w_bits_strb(m_w_bits_strb), .m_w_bits_last(m_w_bits_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_bits_id(m_b_bits_id), .m_b_bits_resp(m_b_bits_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_bits_id(m_ar_bits_id),
    .m_ar_bits_addr(m_ar_bits_addr), .m_ar_bits_len(m_ar_bits_len), .m_ar_bits_size(m_ar_bits_size),
    .m_ar_bits_burst(m_ar_bits_burst), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_bits_id(m_r_bits_id), .m_r_bits_data(m_r_bits_data), .m_r_bits_resp(m_r_bits_resp),
    .m_r_bits_last(m_r_bits_last)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v0;
    logic        v1;
    logic        g;
    logic [31:0] rdata;
  } rd_vec_t;
  rd_vec_t tbl[8];

  logic [14:0] hs_bits;
  assign hs_bits = {s0_aw_ready, s1_aw_ready, s0_w_ready, s1_w_ready, s0_b_valid, s1_b_valid,
                    s0_ar_ready, s1_ar_ready, s0_r_valid, s1_r_valid,
                    m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {s0_aw_valid, s1_aw_valid, s0_w_valid, s1_w_valid, s0_b_ready, s1_b_ready} = '0;
    {s0_ar_valid, s1_ar_valid, s0_r_ready, s1_r_ready} = '0;
    {m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid, m_r_bits_last} = '0;
    s0_aw_bits_id = '0; s1_aw_bits_id = '0; s0_aw_bits_addr = '0; s1_aw_bits_addr = '0;
    s0_aw_bits_len = '0; s1_aw_bits_len = '0; s0_aw_bits_size = 3'd2; s1_aw_bits_size = 3'd2;
    s0_aw_bits_burst = 2'b01; s1_aw_bits_burst = 2'b01;
    s0_ar_bits_id = '0; s1_ar_bits_id = '0; s0_ar_bits_addr = '0; s1_ar_bits_addr = '0;
    s0_ar_bits_len = '0; s1_ar_bits_len = '0; s0_ar_bits_size = 3'd2; s1_ar_bits_size = 3'd2;
    s0_ar_bits_burst = 2'b01; s1_ar_bits_burst = 2'b01;
    s0_w_bits_data = '0; s1_w_bits_data = '0; s0_w_bits_strb = '0; s1_w_bits_strb = '0;
    s0_w_bits_last = 1'b0; s1_w_bits_last = 1'b0;
    m_b_bits_id = '0; m_b_bits_resp = '0; m_r_bits_id = '0; m_r_bits_data = '0; m_r_bits_resp = '0;
  endtask

  task automatic read_txn(input logic v0, input logic v1, input logic g, input logic [31:0] rdata);
    logic [IW-1:0] idg;
    logic [AW-1:0] adg;
    idg = g ? 4'hA : 4'h3;
    adg = g ? 32'h1000_0040 : 32'h0800_0000;
    s0_ar_valid = v0; s1_ar_valid = v1;
    s0_ar_bits_id = 4'h3; s0_ar_bits_addr = 32'h0800_0000; s0_ar_bits_len = 8'd0;
    s1_ar_bits_id = 4'hA; s1_ar_bits_addr = 32'h1000_0040; s1_ar_bits_len = 8'd0;
    #1;
    chk("ar_valid_arb_cycle", m_ar_valid, 1'b0);
    @(negedge clock);
    chk("ar_valid", m_ar_valid, 1'b1);
    chk("ar_id", m_ar_bits_id, {g, idg});
    chk("ar_addr", m_ar_bits_addr, adg);
    m_ar_ready = 1'b1;
    #1;
    chk("ar_ready_granted", g ? s1_ar_ready : s0_ar_ready, 1'b1);
    chk("ar_ready_other", g ? s0_ar_ready : s1_ar_ready, 1'b0);
    @(negedge clock);
    s0_ar_valid = 1'b0; s1_ar_valid = 1'b0; m_ar_ready = 1'b0;
    m_r_valid = 1'b1; m_r_bits_data = rdata; m_r_bits_id = {g, idg}; m_r_bits_last = 1'b1;
    if (g) s1_r_ready = 1'b1; else s0_r_ready = 1'b1;
    #1;
    chk("r_valid_granted", g ? s1_r_valid : s0_r_valid, 1'b1);
    chk("r_valid_other", g ? s0_r_valid : s1_r_valid, 1'b0);
    chk("r_data", g ? s1_r_bits_data : s0_r_bits_data, rdata);
    chk("r_id", g ? s1_r_bits_id : s0_r_bits_id, idg);
    chk("r_last", g ? s1_r_bits_last : s0_r_bits_last, 1'b1);
    chk("m_r_ready", m_r_ready, 1'b1);
    @(negedge clock);
    m_r_valid = 1'b0; m_r_bits_last = 1'b0; s0_r_ready = 1'b0; s1_r_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h1111_0000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h2222_0001};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h3333_0002};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h5555_0004};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h6666_0005};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h7777_0006};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h8888_0007};

    clear_inputs();
    reset = 1'b1;
    s0_ar_valid = 1'b1; s1_aw_valid = 1'b1; m_r_valid = 1'b1; m_b_valid = 1'b1;
    m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1; s0_r_ready = 1'b1; s1_b_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_hs_zero", hs_bits, 15'd0);
    clear_inputs();
    reset = 1'b0;
    @(negedge clock);

    foreach (tbl[i]) read_txn(tbl[i].v0, tbl[i].v1, tbl[i].g, tbl[i].rdata);

    // port 1 write, W presented three cycles ahead of AW; port 0 W pending throughout
    s1_w_valid = 1'b1; s1_w_bits_data = 32'hA5A5_5A5A; s1_w_bits_strb = 4'hF; s1_w_bits_last = 1'b1;
    s0_w_valid = 1'b1; s0_w_bits_data = 32'h0BAD_0BAD; s0_w_bits_last = 1'b1;
    m_w_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w_early_s1_ready", s1_w_ready, 1'b0);
      chk("w_early_m_valid", m_w_valid, 1'b0);
      @(negedge clock);
    end
    s1_aw_valid = 1'b1; s1_aw_bits_id = 4'h5; s1_aw_bits_addr = 32'h0000_1000;
    @(negedge clock);
    chk("wr_aw_valid", m_aw_valid, 1'b1);
    chk("wr_aw_id", m_aw_bits_id, 5'h15);
    chk("wr_w_data", m_w_bits_data, 32'hA5A5_5A5A);
    chk("wr_w_strb", m_w_bits_strb, 4'hF);
    chk("wr_s1_w_ready", s1_w_ready, 1'b1);
    chk("wr_s0_w_ready", s0_w_ready, 1'b0);
    chk("wr_s1_aw_ready_stalled", s1_aw_ready, 1'b0);
    @(negedge clock);
    chk("wr_w_closed", m_w_valid, 1'b0);
    chk("wr_w_closed_ready", s1_w_ready, 1'b0);
    m_aw_ready = 1'b1;
    #1;
    chk("wr_s1_aw_ready", s1_aw_ready, 1'b1);
    @(negedge clock);
    s1_aw_valid = 1'b0; s1_w_valid = 1'b0; s0_w_valid = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
    m_b_valid = 1'b1; m_b_bits_id = 5'h15; m_b_bits_resp = 2'b10; s1_b_ready = 1'b1; s0_b_ready = 1'b1;
    #1;
    chk("b_s1_valid", s1_b_valid, 1'b1);
    chk("b_s0_valid", s0_b_valid, 1'b0);
    chk("b_s1_id", s1_b_bits_id, 4'h5);
    chk("b_s1_resp", s1_b_bits_resp, 2'b10);
    chk("b_m_ready", m_b_ready, 1'b1);
    @(negedge clock);
    chk("b_after_idle", s1_b_valid, 1'b0);
    clear_inputs();
    @(negedge clock);

    // port 1 read burst of 4 beats, each beat stalled one cycle by the master
    s1_ar_valid = 1'b1; s1_ar_bits_id = 4'h6; s1_ar_bits_len = 8'd3; s1_ar_bits_addr = 32'h2000_0000;
    @(negedge clock);
    chk("burst_ar_len", m_ar_bits_len, 8'd3);
    m_ar_ready = 1'b1;
    @(negedge clock);
    s1_ar_valid = 1'b0; m_ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_r_valid = 1'b1; m_r_bits_data = 32'hB000_0000 + i; m_r_bits_id = 5'h16;
      m_r_bits_last = (i == 3); s1_r_ready = 1'b0;
      #1;
      chk("burst_s1_valid", s1_r_valid, 1'b1);
      chk("burst_stall", m_r_ready, 1'b0);
      chk("burst_data", s1_r_bits_data, 32'hB000_0000 + i);
      @(negedge clock);
      s1_r_ready = 1'b1;
      #1;
      chk("burst_m_ready", m_r_ready, 1'b1);
      chk("burst_last", s1_r_bits_last, (i == 3));
      @(negedge clock);
    end
    #1;
    chk("burst_done_idle", s1_r_valid, 1'b0);
    clear_inputs();
    @(negedge clock);

    // concurrent port 0 write and port 1 read
    s0_aw_valid = 1'b1; s0_aw_bits_id = 4'h2; s0_aw_bits_addr = 32'h3000_0000;
    s0_w_valid = 1'b1; s0_w_bits_data = 32'h1234_5678; s0_w_bits_strb = 4'h3; s0_w_bits_last = 1'b1;
    s1_ar_valid = 1'b1; s1_ar_bits_id = 4'h9;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    #1;
    chk("cc_arb_cycle", {m_aw_valid, m_ar_valid}, 2'b00);
    @(negedge clock);
    chk("cc_valids", {m_aw_valid, m_w_valid, m_ar_valid}, 3'b111);
    chk("cc_aw_id", m_aw_bits_id, 5'h02);
    chk("cc_ar_id", m_ar_bits_id, 5'h19);
    chk("cc_readies", {s0_aw_ready, s0_w_ready, s1_ar_ready}, 3'b111);
    @(negedge clock);
    clear_inputs();
    m_b_valid = 1'b1; m_b_bits_id = 5'h02; s0_b_ready = 1'b1;
    m_r_valid = 1'b1; m_r_bits_id = 5'h19; m_r_bits_data = 32'hC0DE_0009; m_r_bits_last = 1'b1; s1_r_ready = 1'b1;
    #1;
    chk("cc_b_route", {s0_b_valid, s1_b_valid}, 2'b10);
    chk("cc_r_route", {s0_r_valid, s1_r_valid}, 2'b01);
    chk("cc_r_data", s1_r_bits_data, 32'hC0DE_0009);
    @(negedge clock);
    chk("cc_done", {s0_b_valid, s1_r_valid}, 2'b00);
    clear_inputs();
    @(negedge clock);

    // reset during the second beat of a port 0 burst
    s0_ar_valid = 1'b1; s0_ar_bits_len = 8'd3; s0_ar_bits_id = 4'h1;
    @(negedge clock);
    m_ar_ready = 1'b1;
    @(negedge clock);
    s0_ar_valid = 1'b0; m_ar_ready = 1'b0;
    m_r_valid = 1'b1; m_r_bits_data = 32'hE000_0000; m_r_bits_id = 5'h01; s0_r_ready = 1'b1;
    @(negedge clock);
    m_r_bits_data = 32'hE000_0001;
    #1;
    chk("rst_beat2_valid", s0_r_valid, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_hs_zero", hs_bits, 15'd0);
    reset = 1'b0;
    clear_inputs();
    read_txn(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
